cla_addsub_pipe: RTL and testbench

- Parametrised, pipelined carry-lookahead adder/subtractor for the datapath ALU.
- Built from 4-bit CLA groups with group generate/propagate.
- Carries ripple between groups through pipeline registers: GPS groups are resolved per stage.
- Supports wrap add, subtract, signed saturating add and nibble-parallel saturating add (PADDSB).
- Valid/ready handshake on both sides, with full-pipeline stall on output backpressure.

---
 rtl/cla_addsub_pipe_if.sv | 27 ++
 rtl/cla_addsub_pipe.sv | 170 +++++++++++++++++
 tb/tb_cla_addsub_pipe.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/cla_addsub_pipe_if.sv
// Operand/result handshake bundle for the pipelined CLA adder/subtractor.
// The master side issues operand beats and accepts results; the slave side is the adder.
interface cla_addsub_pipe_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [1:0]       mode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovfl;
    logic             sat;

    modport master (
        output in_valid, a, b, mode, out_ready,
        input  in_ready, out_valid, sum, cout, ovfl, sat
    );

    modport slave (
        input  in_valid, a, b, mode, out_ready,
        output in_ready, out_valid, sum, cout, ovfl, sat
    );
endinterface

// File: rtl/cla_addsub_pipe.sv
// Pipelined carry-lookahead add/sub/saturating-add built from 4-bit CLA groups.
// GPS groups resolve per stage; the inter-group carry travels in the stage registers.
module cla_addsub_pipe #(
    parameter int WIDTH = 16,
    parameter int GPS   = 1
) (
    input  logic               clk,
    input  logic               rst,
    cla_addsub_pipe_if.slave   bus
);
    localparam int NGROUP = WIDTH / 4;
    localparam int NSTAGE = NGROUP / GPS;

    localparam logic [1:0] MODE_SUB    = 2'b01;
    localparam logic [1:0] MODE_ADDS   = 2'b10;
    localparam logic [1:0] MODE_PADDSB = 2'b11;

    localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    logic             st_valid [NSTAGE];
    logic [1:0]       st_mode  [NSTAGE];
    logic [WIDTH-1:0] st_a     [NSTAGE];
    logic [WIDTH-1:0] st_b     [NSTAGE];
    logic [WIDTH-1:0] st_sum   [NSTAGE];
    logic             st_c     [NSTAGE];

    logic [WIDTH-1:0] nxt_sum  [NSTAGE];
    logic             nxt_c    [NSTAGE];

    logic             stall;
    logic             out_valid_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             ovfl_q;
    logic             sat_q;

    logic [WIDTH-1:0] fin_sum;
    logic             fin_cout;
    logic             fin_ovfl;
    logic             fin_sat;

    // Returns {group carry-out, 4-bit sum}; carry-out uses group generate/propagate.
    function automatic logic [4:0] cla4(input logic [3:0] x, input logic [3:0] y,
                                        input logic ci);
        logic [3:0] g;
        logic [3:0] p;
        logic [4:0] c;
        logic       gg;
        logic       gp;
        g    = x & y;
        p    = x | y;
        c    = '0;
        c[0] = ci;
        for (int i = 0; i < 4; i++) begin
            c[i+1] = g[i] | (p[i] & c[i]);
        end
        gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
        gp = &p;
        return {gg | (gp & ci), x ^ y ^ c[3:0]};
    endfunction

    assign stall         = out_valid_q & ~bus.out_ready;
    assign bus.in_ready  = ~stall;
    assign bus.out_valid = out_valid_q;
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign bus.ovfl      = ovfl_q;
    assign bus.sat       = sat_q;

    // PADDSB forces every group carry-in to zero so the nibbles stay independent.
    always_comb begin
        logic             c;
        logic             cin;
        logic [WIDTH-1:0] ps;
        int               grp;
        c   = 1'b0;
        cin = 1'b0;
        ps  = '0;
        grp = 0;
        for (int s = 0; s < NSTAGE; s++) begin
            c  = st_c[s];
            ps = st_sum[s];
            for (int j = 0; j < GPS; j++) begin
                grp = s * GPS + j;
                cin = (st_mode[s] == MODE_PADDSB) ? 1'b0 : c;
                {c, ps[grp*4 +: 4]} = cla4(st_a[s][grp*4 +: 4], st_b[s][grp*4 +: 4], cin);
            end
            nxt_sum[s] = ps;
            nxt_c[s]   = c;
        end
    end

    always_comb begin
        logic [WIDTH-1:0] fa;
        logic [WIDTH-1:0] fb;
        logic [WIDTH-1:0] raw;
        logic             ov_n;
        fa       = st_a[NSTAGE-1];
        fb       = st_b[NSTAGE-1];
        raw      = nxt_sum[NSTAGE-1];
        ov_n     = 1'b0;
        fin_sum  = raw;
        fin_cout = nxt_c[NSTAGE-1];
        fin_sat  = 1'b0;
        fin_ovfl = (fa[WIDTH-1] == fb[WIDTH-1]) && (raw[WIDTH-1] != fa[WIDTH-1]);
        if (st_mode[NSTAGE-1] == MODE_PADDSB) begin
            fin_ovfl = 1'b0;
            for (int n = 0; n < NGROUP; n++) begin
                ov_n = (fa[4*n+3] == fb[4*n+3]) && (raw[4*n+3] != fa[4*n+3]);
                if (ov_n) begin
                    fin_sum[4*n +: 4] = fa[4*n+3] ? 4'h8 : 4'h7;
                end
                fin_ovfl = fin_ovfl | ov_n;
            end
            fin_sat = fin_ovfl;
        end else if ((st_mode[NSTAGE-1] == MODE_ADDS) && fin_ovfl) begin
            fin_sum = fa[WIDTH-1] ? SAT_MIN : SAT_MAX;
            fin_sat = 1'b1;
        end
    end

    // Operands are inverted for SUB at accept; the whole pipe freezes on backpressure.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < NSTAGE; s++) begin
                st_valid[s] <= 1'b0;
                st_mode[s]  <= '0;
                st_a[s]     <= '0;
                st_b[s]     <= '0;
                st_sum[s]   <= '0;
                st_c[s]     <= 1'b0;
            end
        end else if (!stall) begin
            st_valid[0] <= bus.in_valid;
            st_mode[0]  <= bus.mode;
            st_a[0]     <= bus.a;
            st_b[0]     <= (bus.mode == MODE_SUB) ? ~bus.b : bus.b;
            st_sum[0]   <= '0;
            st_c[0]     <= (bus.mode == MODE_SUB);
            for (int s = 1; s < NSTAGE; s++) begin
                st_valid[s] <= st_valid[s-1];
                st_mode[s]  <= st_mode[s-1];
                st_a[s]     <= st_a[s-1];
                st_b[s]     <= st_b[s-1];
                st_sum[s]   <= nxt_sum[s-1];
                st_c[s]     <= nxt_c[s-1];
            end
        end
    end

    // Result fields only change when a real beat leaves the last stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            ovfl_q      <= 1'b0;
            sat_q       <= 1'b0;
        end else if (!stall) begin
            out_valid_q <= st_valid[NSTAGE-1];
            if (st_valid[NSTAGE-1]) begin
                sum_q  <= fin_sum;
                cout_q <= fin_cout;
                ovfl_q <= fin_ovfl;
                sat_q  <= fin_sat;
            end
        end
    end
endmodule

// File: tb/tb_cla_addsub_pipe.sv
// Scoreboard bench: directed beats push hand-computed results, per-DUT monitors pop and compare.
// Covers a 16-bit GPS=1 instance (stall/throughput) and a 32-bit GPS=2 instance (async reset).
module tb_cla_addsub_pipe;
    localparam logic [1:0] M_ADD    = 2'b00;
    localparam logic [1:0] M_SUB    = 2'b01;
    localparam logic [1:0] M_ADDS   = 2'b10;
    localparam logic [1:0] M_PADDSB = 2'b11;

    typedef struct packed {
        logic [31:0] sum;
        logic        cout;
        logic        ovfl;
        logic        sat;
    } exp_t;

    logic clk = 1'b0;
    logic rst0;
    logic rst1;
    always #5 clk = ~clk;

    cla_addsub_pipe_if #(.WIDTH(16)) bus0 ();
    cla_addsub_pipe_if #(.WIDTH(32)) bus1 ();

    cla_addsub_pipe #(.WIDTH(16), .GPS(1)) dut0 (.clk(clk), .rst(rst0), .bus(bus0.slave));
    cla_addsub_pipe #(.WIDTH(32), .GPS(2)) dut1 (.clk(clk), .rst(rst1), .bus(bus1.slave));

    exp_t q0[$];
    exp_t q1[$];
    int   out_cyc0[$];
    int   out_cyc1[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   acc_cyc = 0;
    exp_t e0;
    exp_t e1;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic exp_t mk(input logic [31:0] s, input logic c, input logic o,
                                input logic sa);
        exp_t e;
        e.sum  = s;
        e.cout = c;
        e.ovfl = o;
        e.sat  = sa;
        return e;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst0 && bus0.out_valid && bus0.out_ready) begin
            out_cyc0.push_back(cyc);
            if (q0.size() == 0) begin
                checkOutput("d0 unexpected output", 32'd1, 32'd0);
            end else begin
                e0 = q0.pop_front();
                checkOutput("d0 sum",  {16'h0, bus0.sum}, e0.sum);
                checkOutput("d0 cout", {31'h0, bus0.cout}, {31'h0, e0.cout});
                checkOutput("d0 ovfl", {31'h0, bus0.ovfl}, {31'h0, e0.ovfl});
                checkOutput("d0 sat",  {31'h0, bus0.sat},  {31'h0, e0.sat});
            end
        end
    end

    always @(negedge clk) begin
        if (!rst1 && bus1.out_valid && bus1.out_ready) begin
            out_cyc1.push_back(cyc);
            if (q1.size() == 0) begin
                checkOutput("d1 unexpected output", 32'd1, 32'd0);
            end else begin
                e1 = q1.pop_front();
                checkOutput("d1 sum",  bus1.sum, e1.sum);
                checkOutput("d1 cout", {31'h0, bus1.cout}, {31'h0, e1.cout});
                checkOutput("d1 ovfl", {31'h0, bus1.ovfl}, {31'h0, e1.ovfl});
                checkOutput("d1 sat",  {31'h0, bus1.sat},  {31'h0, e1.sat});
            end
        end
    end

    // Called just after a rising edge; returns just after the edge that accepted the beat.
    task automatic applyStimulus(input int d, input logic [1:0] m, input logic [31:0] av,
                                 input logic [31:0] bv, input exp_t e);
        bit accepted;
        accepted = 1'b0;
        if (d == 0) begin
            bus0.in_valid = 1'b1;
            bus0.mode     = m;
            bus0.a        = av[15:0];
            bus0.b        = bv[15:0];
        end else begin
            bus1.in_valid = 1'b1;
            bus1.mode     = m;
            bus1.a        = av;
            bus1.b        = bv;
        end
        for (int i = 0; i < 50 && !accepted; i++) begin
            @(negedge clk);
            if ((d == 0) ? bus0.in_ready : bus1.in_ready) begin
                accepted = 1'b1;
                acc_cyc  = cyc + 1;
                if (d == 0) q0.push_back(e);
                else        q1.push_back(e);
            end
            @(posedge clk);
            #1;
        end
        if (!accepted) checkOutput("accept timeout", 32'd0, 32'd1);
    endtask

    task automatic idle_input(input int d);
        if (d == 0) bus0.in_valid = 1'b0;
        else        bus1.in_valid = 1'b0;
    endtask

    task automatic wait_empty(input int d);
        for (int i = 0; i < 100 && ((d == 0) ? q0.size() : q1.size()) != 0; i++) begin
            @(negedge clk);
        end
        checkOutput("drain", (d == 0) ? q0.size() : q1.size(), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit seen;
        int lat;
        rst0 = 1'b1;
        rst1 = 1'b1;
        bus0.in_valid = 1'b0; bus0.a = '0; bus0.b = '0; bus0.mode = '0; bus0.out_ready = 1'b1;
        bus1.in_valid = 1'b0; bus1.a = '0; bus1.b = '0; bus1.mode = '0; bus1.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst d0 in_ready",  {31'h0, bus0.in_ready},  32'd1);
        checkOutput("rst d0 out_valid", {31'h0, bus0.out_valid}, 32'd0);
        checkOutput("rst d0 sum",       {16'h0, bus0.sum},       32'd0);
        checkOutput("rst d0 cout",      {31'h0, bus0.cout},      32'd0);
        checkOutput("rst d0 ovfl",      {31'h0, bus0.ovfl},      32'd0);
        checkOutput("rst d0 sat",       {31'h0, bus0.sat},       32'd0);
        checkOutput("rst d1 out_valid", {31'h0, bus1.out_valid}, 32'd0);
        checkOutput("rst d1 in_ready",  {31'h0, bus1.in_ready},  32'd1);
        rst0 = 1'b0;
        rst1 = 1'b0;
        @(posedge clk);
        #1;

        // Test-plan vectors on the 16-bit pipe, with a latency check on the first one.
        out_cyc0.delete();
        applyStimulus(0, M_ADD, 32'h7FFF, 32'h0001, mk(32'h8000, 1'b0, 1'b1, 1'b0));
        lat = acc_cyc;
        idle_input(0);
        wait_empty(0);
        checkOutput("d0 latency", (out_cyc0.size() > 0) ? out_cyc0[0] - lat : -1, 32'd4);
        applyStimulus(0, M_ADDS,   32'h7FFF, 32'h0001, mk(32'h7FFF, 1'b0, 1'b1, 1'b1));
        applyStimulus(0, M_ADDS,   32'h8000, 32'hFFFF, mk(32'h8000, 1'b1, 1'b1, 1'b1));
        applyStimulus(0, M_SUB,    32'h0000, 32'h0001, mk(32'hFFFF, 1'b0, 1'b0, 1'b0));
        applyStimulus(0, M_SUB,    32'h0005, 32'h0003, mk(32'h0002, 1'b1, 1'b0, 1'b0));
        applyStimulus(0, M_PADDSB, 32'h781F, 32'h1811, mk(32'h7820, 1'b0, 1'b1, 1'b1));
        idle_input(0);
        wait_empty(0);

        // Eight back-to-back beats with out_ready low for three cycles mid-stream.
        out_cyc0.delete();
        fork
            begin
                applyStimulus(0, M_ADD,    32'hFFFF, 32'h1111, mk(32'h1110, 1'b1, 1'b0, 1'b0));
                applyStimulus(0, M_PADDSB, 32'hFFFF, 32'h1111, mk(32'h0000, 1'b1, 1'b0, 1'b0));
                applyStimulus(0, M_ADDS,   32'h0100, 32'h0200, mk(32'h0300, 1'b0, 1'b0, 1'b0));
                applyStimulus(0, M_SUB,    32'h8000, 32'h0001, mk(32'h7FFF, 1'b1, 1'b1, 1'b0));
                applyStimulus(0, M_ADDS,   32'hFFFE, 32'hFFFF, mk(32'hFFFD, 1'b1, 1'b0, 1'b0));
                applyStimulus(0, M_PADDSB, 32'h1234, 32'h4321, mk(32'h5555, 1'b0, 1'b0, 1'b0));
                applyStimulus(0, M_ADD,    32'h1234, 32'h4321, mk(32'h5555, 1'b0, 1'b0, 1'b0));
                applyStimulus(0, M_ADDS,   32'h8000, 32'h8000, mk(32'h8000, 1'b1, 1'b1, 1'b1));
                idle_input(0);
            end
            begin
                seen = 1'b0;
                for (int i = 0; i < 50 && !seen; i++) begin
                    @(negedge clk);
                    seen = bus0.out_valid;
                end
                checkOutput("stream out_valid seen", {31'h0, seen}, 32'd1);
                repeat (2) @(posedge clk);
                #1;
                bus0.out_ready = 1'b0;
                for (int i = 0; i < 3; i++) begin
                    @(negedge clk);
                    checkOutput("stall in_ready",  {31'h0, bus0.in_ready},  32'd0);
                    checkOutput("stall out_valid", {31'h0, bus0.out_valid}, 32'd1);
                end
                @(posedge clk);
                #1;
                bus0.out_ready = 1'b1;
            end
        join
        wait_empty(0);
        checkOutput("stream count", out_cyc0.size(), 32'd8);
        checkOutput("stream span",
                    (out_cyc0.size() == 8) ? out_cyc0[7] - out_cyc0[0] : -1, 32'd10);

        // 32-bit GPS=2 pipe: leave a nonzero result parked, then reset with beats in flight.
        applyStimulus(1, M_ADD, 32'hFFFF_FFFF, 32'h0000_0002, mk(32'h1, 1'b1, 1'b0, 1'b0));
        idle_input(1);
        wait_empty(1);
        applyStimulus(1, M_ADD, 32'h1, 32'h1, mk(32'h2, 1'b0, 1'b0, 1'b0));
        applyStimulus(1, M_ADD, 32'h2, 32'h2, mk(32'h4, 1'b0, 1'b0, 1'b0));
        applyStimulus(1, M_ADD, 32'h3, 32'h3, mk(32'h6, 1'b0, 1'b0, 1'b0));
        idle_input(1);
        @(negedge clk);
        #2;
        rst1 = 1'b1;
        q1.delete();
        #1;
        checkOutput("async rst out_valid", {31'h0, bus1.out_valid}, 32'd0);
        checkOutput("async rst sum",       bus1.sum,                32'd0);
        checkOutput("async rst cout",      {31'h0, bus1.cout},      32'd0);
        @(negedge clk);
        rst1 = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            seen = seen | bus1.out_valid;
        end
        checkOutput("stale after rst", {31'h0, seen}, 32'd0);
        @(posedge clk);
        #1;
        out_cyc1.delete();
        applyStimulus(1, M_SUB, 32'h8000_0000, 32'h0000_0001,
                      mk(32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0));
        lat = acc_cyc;
        applyStimulus(1, M_ADDS, 32'h7FFF_FFFF, 32'h7FFF_FFFF,
                      mk(32'h7FFF_FFFF, 1'b0, 1'b1, 1'b1));
        applyStimulus(1, M_PADDSB, 32'h1234_7788, 32'h1111_1188,
                      mk(32'h2345_7788, 1'b0, 1'b1, 1'b1));
        idle_input(1);
        wait_empty(1);
        checkOutput("d1 latency", (out_cyc1.size() > 0) ? out_cyc1[0] - lat : -1, 32'd4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
